// File: rtl/rf_writeback_queue_if.sv
// Handshake, register-file write port and forwarding lookup of the writeback queue.
// The master side feeds requests and lookups; the slave side is the queue itself.
interface rf_writeback_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          WE3;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic [AW-1:0] lk_addr1;
  logic [AW-1:0] lk_addr2;
  logic          lk_hit1;
  logic          lk_hit2;
  logic [DW-1:0] lk_data1;
  logic [DW-1:0] lk_data2;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_addr, in_data, lk_addr1, lk_addr2,
    input  in_ready, WE3, A3, WD3, lk_hit1, lk_hit2, lk_data1, lk_data2, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, lk_addr1, lk_addr2,
    output in_ready, WE3, A3, WD3, lk_hit1, lk_hit2, lk_data1, lk_data2, count
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO in front of the register-file write port, with a
// two-port youngest-match lookup so decode can forward not-yet-written values.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_writeback_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;
  logic [PW-1:0]    idx;

  assign bus.in_ready = (count_q < CW'(DEPTH));
  // Writes to x0 are architecturally void, so they are swallowed at the door.
  assign push         = bus.in_valid & bus.in_ready & (bus.in_addr != '0);
  assign pop          = (count_q != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= bus.in_addr;
      data_q[wr_ptr] <= bus.in_data;
    end
  end

  assign bus.count = count_q;
  assign bus.WE3   = pop;
  assign bus.A3    = pop ? addr_q[rd_ptr] : '0;
  assign bus.WD3   = pop ? data_q[rd_ptr] : '0;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    bus.lk_hit1  = 1'b0;
    bus.lk_hit2  = 1'b0;
    bus.lk_data1 = '0;
    bus.lk_data2 = '0;
    idx          = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (vld_q[idx] && (bus.lk_addr1 != '0) && (addr_q[idx] == bus.lk_addr1)) begin
        bus.lk_hit1  = 1'b1;
        bus.lk_data1 = data_q[idx];
      end
      if (vld_q[idx] && (bus.lk_addr2 != '0) && (addr_q[idx] == bus.lk_addr2)) begin
        bus.lk_hit2  = 1'b1;
        bus.lk_data2 = data_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: reference queue model checked every cycle,
// a lookup vector table, and hand sequences for drain order and reset.
module tb_rf_writeback_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = 3;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] lk1;
    logic [AW-1:0] lk2;
    logic          hit1;
    logic [DW-1:0] dat1;
    logic          hit2;
    logic [DW-1:0] dat2;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;
  ent_t q[$];
  logic [AW-1:0] wlog[$];
  int   we_cycles = 0;

  rf_writeback_queue_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

  rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference queue: pop the head at every edge it is non-empty, then enqueue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      bit acc;
      acc = bus.in_valid && (q.size() < DEPTH) && (bus.in_addr != '0);
      if (q.size() != 0) void'(q.pop_front());
      if (acc) q.push_back('{a: bus.in_addr, d: bus.in_data});
    end
  end

  function automatic void lookup(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a != '0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == a) begin
          hit = 1'b1;
          d   = q[i].d;
          break;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic          h;
      logic [DW-1:0] d;
      check("count", DW'(bus.count), DW'(q.size()));
      check("in_ready", DW'(bus.in_ready), DW'(q.size() < DEPTH));
      check("we3", DW'(bus.WE3), DW'(q.size() != 0));
      check("a3", DW'(bus.A3), (q.size() != 0) ? DW'(q[0].a) : '0);
      check("wd3", bus.WD3, (q.size() != 0) ? q[0].d : '0);
      lookup(bus.lk_addr1, h, d);
      check("lk_hit1", DW'(bus.lk_hit1), DW'(h));
      check("lk_data1", bus.lk_data1, d);
      lookup(bus.lk_addr2, h, d);
      check("lk_hit2", DW'(bus.lk_hit2), DW'(h));
      check("lk_data2", bus.lk_data2, d);
    end
    if (bus.WE3) begin
      wlog.push_back(bus.A3);
      we_cycles++;
    end
  end

  task automatic push_seq(input int n, input int base, input logic [DW-1:0] dbase);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = AW'(base + i);
      bus.in_data  = dbase + DW'(i);
      bus.lk_addr1 = AW'(base + i - 1);
      step();
    end
    bus.in_valid = 1'b0;
    bus.lk_addr1 = '0;
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{addr: 5'd5,  data: 32'h11,   lk1: 5'd5,  lk2: 5'd3,  hit1: 1, dat1: 32'h11, hit2: 0, dat2: 0};
    vt[1] = '{addr: 5'd3,  data: 32'h22,   lk1: 5'd5,  lk2: 5'd3,  hit1: 0, dat1: 0,      hit2: 1, dat2: 32'h22};
    vt[2] = '{addr: 5'd0,  data: 32'hFFFF, lk1: 5'd0,  lk2: 5'd3,  hit1: 0, dat1: 0,      hit2: 0, dat2: 0};
    vt[3] = '{addr: 5'd7,  data: 32'h33,   lk1: 5'd0,  lk2: 5'd7,  hit1: 0, dat1: 0,      hit2: 1, dat2: 32'h33};
    vt[4] = '{addr: 5'd9,  data: 32'h44,   lk1: 5'd9,  lk2: 5'd9,  hit1: 1, dat1: 32'h44, hit2: 1, dat2: 32'h44};
    vt[5] = '{addr: 5'd31, data: 32'hDEAD, lk1: 5'd31, lk2: 5'd30, hit1: 1, dat1: 32'hDEAD, hit2: 0, dat2: 0};

    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.lk_addr1 = '0;
    bus.lk_addr2 = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_we3", DW'(bus.WE3), 0);
    check("rst_ready", DW'(bus.in_ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single push drains the following cycle, then the queue is empty.
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd5;
    bus.in_data  = 32'h11;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t1_we3", DW'(bus.WE3), 1);
    check("t1_a3", DW'(bus.A3), 5);
    check("t1_wd3", bus.WD3, 32'h11);
    step();
    @(negedge clk);
    check("t1_idle_we3", DW'(bus.WE3), 0);
    check("t1_idle_cnt", DW'(bus.count), 0);
    step();

    // Lookup table: row i is pushed while row i-1 is the pending entry.
    for (int i = 0; i <= 6; i++) begin
      bus.in_valid = (i < 6);
      bus.in_addr  = (i < 6) ? vt[i].addr : '0;
      bus.in_data  = (i < 6) ? vt[i].data : '0;
      bus.lk_addr1 = (i > 0) ? vt[i-1].lk1 : '0;
      bus.lk_addr2 = (i > 0) ? vt[i-1].lk2 : '0;
      @(negedge clk);
      if (i > 0) begin
        check("vec_hit1", DW'(bus.lk_hit1), DW'(vt[i-1].hit1));
        check("vec_data1", bus.lk_data1, vt[i-1].dat1);
        check("vec_hit2", DW'(bus.lk_hit2), DW'(vt[i-1].hit2));
        check("vec_data2", bus.lk_data2, vt[i-1].dat2);
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.lk_addr1 = '0;
    bus.lk_addr2 = '0;
    step();

    // Burst of four keeps push order on the write port.
    wlog.delete();
    push_seq(4, 1, 32'h100);
    repeat (3) step();
    check("burst_len", DW'(wlog.size()), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      check("burst_order", DW'(wlog[i]), DW'(i + 1));

    // Same rd twice: both values drain in order, last one wins.
    wlog.delete();
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd6;
    bus.in_data  = 32'hA;
    bus.lk_addr1 = 5'd6;
    step();
    bus.in_data = 32'hB;
    @(negedge clk);
    check("dup_wd3_first", bus.WD3, 32'hA);
    check("dup_lk_first", bus.lk_data1, 32'hA);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("dup_wd3_second", bus.WD3, 32'hB);
    check("dup_lk_second", bus.lk_data1, 32'hB);
    step();
    bus.lk_addr1 = '0;
    step();

    // rd=0 is accepted but never written.
    wlog.delete();
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd0;
    bus.in_data  = 32'hFFFF;
    repeat (3) step();
    bus.in_valid = 1'b0;
    step();
    check("x0_no_write", DW'(wlog.size()), 0);

    // Continuous stream of 20 distinct rd values.
    wlog.delete();
    we_cycles = 0;
    push_seq(20, 1, 32'h1000);
    repeat (3) step();
    check("stream_we_cycles", DW'(we_cycles), 20);
    check("stream_len", DW'(wlog.size()), 20);
    for (int i = 0; i < 20 && i < wlog.size(); i++)
      check("stream_order", DW'(wlog[i]), DW'(i + 1));

    // Asynchronous reset mid-cycle while writes are pending.
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd10;
    bus.in_data  = 32'h55;
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    check("arst_we3", DW'(bus.WE3), 0);
    check("arst_cnt", DW'(bus.count), 0);
    check("arst_wd3", bus.WD3, 0);
    bus.in_valid = 1'b0;
    step();
    rst = 1'b0;
    wlog.delete();
    repeat (5) step();
    check("arst_no_write", DW'(wlog.size()), 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
